// File: rtl/apu_wb_if.sv
// ============================================================================
// Module   : apu_wb_if
// Brief    : Issue / writeback / RAW-check bundle for apu_wb_scheduler.
//            APU_WB_STALL_STATS_EN adds the stall_cnt_o statistic.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface apu_wb_if #(
   parameter int TAG_W        = 6,
   parameter int NUM_RD_PORTS = 3,
   parameter int CNT_W        = 4
);
   logic                          issue_valid_i;
   logic [2:0]                    issue_class_i;
   logic [TAG_W-1:0]              issue_tag_i;
   logic                          issue_ready_o;
   logic                          illegal_o;
   logic                          flush_i;
   logic                          wb_valid_o;
   logic [TAG_W-1:0]              wb_tag_o;
   logic [NUM_RD_PORTS*TAG_W-1:0] rd_addr_i;
   logic [NUM_RD_PORTS-1:0]       rd_hazard_o;
   logic [CNT_W-1:0]              outstanding_o;
   logic                          idle_o;
`ifdef APU_WB_STALL_STATS_EN
   logic [31:0]                   stall_cnt_o;
`endif

   modport slave (
`ifdef APU_WB_STALL_STATS_EN
      output stall_cnt_o,
`endif
      input  issue_valid_i, issue_class_i, issue_tag_i, flush_i, rd_addr_i,
      output issue_ready_o, illegal_o, wb_valid_o, wb_tag_o, rd_hazard_o,
             outstanding_o, idle_o
   );

   modport master (
`ifdef APU_WB_STALL_STATS_EN
      input  stall_cnt_o,
`endif
      output issue_valid_i, issue_class_i, issue_tag_i, flush_i, rd_addr_i,
      input  issue_ready_o, illegal_o, wb_valid_o, wb_tag_o, rd_hazard_o,
             outstanding_o, idle_o
   );
endinterface

`default_nettype wire

// File: rtl/apu_wb_scheduler.sv
// ============================================================================
// Module   : apu_wb_scheduler
// Brief    : Fixed-latency APU writeback scheduler with shift-register
//            reservation table, WAW issue blocking and RAW hazard flags.
//            Optional macro: APU_WB_STALL_STATS_EN (stall cycle counter).
// Revision : 1.0
// ============================================================================
`default_nettype none

module apu_wb_scheduler #(
   parameter int TAG_W        = 6,
   parameter int MAX_LAT      = 8,
   parameter int NUM_RD_PORTS = 3,
   parameter int LAT_ADDSUB   = 1,
   parameter int LAT_MULT     = 1,
   parameter int LAT_CAST     = 1,
   parameter int LAT_MAC      = 2,
   parameter int LAT_DIV      = 4,
   parameter int LAT_SQRT     = 5
) (
   input  wire logic clk,
   input  wire logic rst,
   apu_wb_if.slave   io_bus
);

   localparam int LW = $clog2(MAX_LAT + 1);
   localparam int IW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   if (LAT_ADDSUB < 1 || LAT_ADDSUB > MAX_LAT || LAT_MULT < 1 || LAT_MULT > MAX_LAT ||
       LAT_CAST   < 1 || LAT_CAST   > MAX_LAT || LAT_MAC  < 1 || LAT_MAC  > MAX_LAT ||
       LAT_DIV    < 1 || LAT_DIV    > MAX_LAT || LAT_SQRT < 1 || LAT_SQRT > MAX_LAT)
   begin : g_lat_check
      $error("apu_wb_scheduler: every LAT_* must lie in 1..MAX_LAT");
   end

   logic [MAX_LAT-1:0]      r_vld;
   logic [TAG_W-1:0]        r_tag [MAX_LAT];
   logic [LW-1:0]           r_out;

   logic [LW-1:0]           w_lat;
   logic [IW-1:0]           w_wr_idx;
   logic                    w_cls_ok;
   logic                    w_slot_busy;
   logic                    w_waw;
   logic                    w_ready;
   logic                    w_accept;
   logic [NUM_RD_PORTS-1:0] w_hazard;

   always_comb begin
      w_lat = LW'(LAT_ADDSUB);
      case (io_bus.issue_class_i)
         3'd1:    w_lat = LW'(LAT_MULT);
         3'd2:    w_lat = LW'(LAT_CAST);
         3'd3:    w_lat = LW'(LAT_MAC);
         3'd4:    w_lat = LW'(LAT_DIV);
         3'd5:    w_lat = LW'(LAT_SQRT);
         default: w_lat = LW'(LAT_ADDSUB);
      endcase
   end

   assign w_cls_ok = (io_bus.issue_class_i <= 3'd5);
   assign w_wr_idx = IW'(w_lat - LW'(1));

   // A latency of MAX_LAT never matches an index, so that result slot always reads free.
   always_comb begin
      w_slot_busy = 1'b0;
      w_waw       = 1'b0;
      for (int i = 0; i < MAX_LAT; i++) begin
         if (r_vld[i] && (LW'(i) == w_lat))
            w_slot_busy = 1'b1;
         if (r_vld[i] && (r_tag[i] == io_bus.issue_tag_i))
            w_waw = 1'b1;
      end
   end

   assign w_ready  = !io_bus.flush_i && w_cls_ok && !w_slot_busy && !w_waw;
   assign w_accept = io_bus.issue_valid_i && w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         for (int i = 0; i < MAX_LAT; i++) r_tag[i] <= '0;
         r_out <= '0;
      end else if (io_bus.flush_i) begin
         r_vld <= '0;
         for (int i = 0; i < MAX_LAT; i++) r_tag[i] <= '0;
         r_out <= '0;
      end else begin
         r_vld <= {1'b0, r_vld[MAX_LAT-1:1]};
         for (int i = 0; i < MAX_LAT - 1; i++) r_tag[i] <= r_tag[i+1];
         r_tag[MAX_LAT-1] <= '0;
         if (w_accept) begin
            r_vld[w_wr_idx] <= 1'b1;
            r_tag[w_wr_idx] <= io_bus.issue_tag_i;
         end
         case ({w_accept, r_vld[0]})
            2'b10:   r_out <= r_out + LW'(1);
            2'b01:   r_out <= r_out - LW'(1);
            default: r_out <= r_out;
         endcase
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
      logic [TAG_W-1:0] w_src;
      logic             w_hit;
      assign w_src = io_bus.rd_addr_i[p*TAG_W +: TAG_W];
      always_comb begin
         w_hit = 1'b0;
         for (int i = 0; i < MAX_LAT; i++)
            if (r_vld[i] && (r_tag[i] == w_src)) w_hit = 1'b1;
      end
      assign w_hazard[p] = w_hit;
   end

`ifdef APU_WB_STALL_STATS_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (io_bus.issue_valid_i && !w_ready && w_cls_ok && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign io_bus.stall_cnt_o = r_stall_cnt;
`endif

   assign io_bus.issue_ready_o = w_ready;
   assign io_bus.illegal_o     = io_bus.issue_valid_i && !w_cls_ok;
   assign io_bus.wb_valid_o    = r_vld[0];
   assign io_bus.wb_tag_o      = r_tag[0];
   assign io_bus.rd_hazard_o   = w_hazard;
   assign io_bus.outstanding_o = r_out;
   assign io_bus.idle_o        = (r_out == '0);

endmodule

`default_nettype wire
